// File: rtl/ifu_pkg.sv
// Shared types and sizing helpers for the instruction prefetch unit.
// Optional performance counters are enabled with the IFU_PERF_CNT_EN macro.
package ifu_pkg;

    localparam logic [31:0] IFU_ADDR_INIT = 32'h8000_0000;
    localparam int          IFU_ADDR_W    = 32;
    localparam int          IFU_DATA_W    = 32;

    typedef struct packed {
        logic [IFU_ADDR_W-1:0] pc;
        logic [IFU_DATA_W-1:0] inst;
    } fetch_entry_t;

    // Width able to hold 0..depth inclusive (credits, fill level).
    function automatic int ifu_cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

    localparam int IFU_CNT_W = ifu_cnt_w(4);

endpackage

// File: rtl/ifu_fifo.sv
// Power-of-two entry queue with synchronous flush and fill-level output.
// Head entry is read straight from storage so it stays put while not popped.
module ifu_fifo
    import ifu_pkg::*;
#(
    parameter int                    DEPTH   = 4,
    parameter type                   T       = fetch_entry_t,
    parameter logic [$bits(T)-1:0]   RST_VAL = '0
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic                       i_flush,
    input  logic                       i_push,
    input  T                           i_data,
    input  logic                       i_pop,
    output T                           o_head,
    output logic [ifu_cnt_w(DEPTH)-1:0] o_count
);

    localparam int CW = ifu_cnt_w(DEPTH);
    localparam int PW = $clog2(DEPTH);

    T               r_mem [DEPTH];
    logic [PW-1:0]  r_wr_ptr;
    logic [PW-1:0]  r_rd_ptr;
    logic [CW-1:0]  r_count;

    // Storage, pointers and fill level; flush wins over push/pop.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= T'(RST_VAL);
            end
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) begin
                r_mem[r_wr_ptr] <= i_data;
                r_wr_ptr        <= r_wr_ptr + PW'(1);
            end
            if (i_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_count = r_count;

endmodule

// File: rtl/ifu_prefetch.sv
// Sequential instruction prefetcher with credit-based request issue and jump flush.
// Define IFU_PERF_CNT_EN to add fetch/flush performance counter outputs.
module ifu_prefetch
    import ifu_pkg::*;
#(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] ADDR_INIT  = ADDR_WIDTH'(IFU_ADDR_INIT),
    parameter int                    DEPTH      = 4,
    parameter int                    PC_STEP    = 4
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    output logic                  o_req_valid,
    input  logic                  i_req_ready,
    output logic [ADDR_WIDTH-1:0] o_req_addr,
    input  logic                  i_rsp_valid,
    input  logic [DATA_WIDTH-1:0] i_rsp_data,
    input  logic                  i_jmp_en,
    input  logic [ADDR_WIDTH-1:0] i_jmp_pc,
    output logic                  o_valid,
    input  logic                  i_ready,
`ifdef IFU_PERF_CNT_EN
    output logic [31:0]           o_perf_fetch_cnt,
    output logic [31:0]           o_perf_flush_cnt,
`endif
    output logic [ADDR_WIDTH-1:0] o_pc,
    output logic [DATA_WIDTH-1:0] o_inst
);

    localparam int CW  = ifu_cnt_w(DEPTH);
    localparam int DRW = CW + 2;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] pc;
        logic [DATA_WIDTH-1:0] inst;
    } entry_t;

    localparam logic [ADDR_WIDTH+DATA_WIDTH-1:0] ENTRY_RST = {ADDR_INIT, {DATA_WIDTH{1'b0}}};

    logic                  r_run;
    logic [ADDR_WIDTH-1:0] r_req_pc;
    logic [ADDR_WIDTH-1:0] r_rsp_pc;
    logic [CW-1:0]         r_outst;
    logic [DRW-1:0]        r_drop;

    logic [CW-1:0]         w_count;
    entry_t                w_head;
    entry_t                w_push_data;
    logic                  w_credit_ok;
    logic                  w_accept;
    logic                  w_rsp_drop;
    logic                  w_rsp_take;
    logic                  w_push;
    logic                  w_pop;

    // Queued entries plus in-flight requests never exceed DEPTH, so the queue cannot overflow.
    assign w_credit_ok = ({1'b0, w_count} + {1'b0, r_outst}) < (CW+1)'(DEPTH);
    assign o_req_valid = r_run & ~i_jmp_en & w_credit_ok;
    assign o_req_addr  = r_req_pc;
    assign w_accept    = o_req_valid & i_req_ready;

    assign w_rsp_drop  = i_rsp_valid & (r_drop != '0);
    assign w_rsp_take  = i_rsp_valid & (r_drop == '0) & (r_outst != '0);
    assign w_push      = w_rsp_take & ~i_jmp_en;
    assign o_valid     = (w_count != '0);
    assign w_pop       = o_valid & i_ready & ~i_jmp_en;

    assign w_push_data.pc   = r_rsp_pc;
    assign w_push_data.inst = i_rsp_data;
    assign o_pc             = w_head.pc;
    assign o_inst           = w_head.inst;

    ifu_fifo #(
        .DEPTH   (DEPTH),
        .T       (entry_t),
        .RST_VAL (ENTRY_RST)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_flush (i_jmp_en),
        .i_push  (w_push),
        .i_data  (w_push_data),
        .i_pop   (w_pop),
        .o_head  (w_head),
        .o_count (w_count)
    );

    // Holds off the first request until the cycle after reset release.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_run <= 1'b0;
        end else begin
            r_run <= 1'b1;
        end
    end

    // Request PC and the PC tag of the oldest live response; both restart at a jump target.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_req_pc <= ADDR_INIT;
            r_rsp_pc <= ADDR_INIT;
        end else if (i_jmp_en) begin
            r_req_pc <= i_jmp_pc;
            r_rsp_pc <= i_jmp_pc;
        end else begin
            if (w_accept) begin
                r_req_pc <= r_req_pc + ADDR_WIDTH'(PC_STEP);
            end
            if (w_rsp_take) begin
                r_rsp_pc <= r_rsp_pc + ADDR_WIDTH'(PC_STEP);
            end
        end
    end

    // In-flight bookkeeping: a jump turns every live request into one to be discarded.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_outst <= '0;
            r_drop  <= '0;
        end else if (i_jmp_en) begin
            r_outst <= '0;
            r_drop  <= r_drop + DRW'(r_outst) - DRW'(w_rsp_drop | w_rsp_take);
        end else begin
            case ({w_accept, w_rsp_take})
                2'b10:   r_outst <= r_outst + CW'(1);
                2'b01:   r_outst <= r_outst - CW'(1);
                default: r_outst <= r_outst;
            endcase
            r_drop <= r_drop - DRW'(w_rsp_drop);
        end
    end

`ifdef IFU_PERF_CNT_EN
    logic [31:0] r_fetch_cnt;
    logic [31:0] r_flush_cnt;

    // Free-running wrap-around event counters.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_fetch_cnt <= 32'd0;
            r_flush_cnt <= 32'd0;
        end else begin
            if (w_push) begin
                r_fetch_cnt <= r_fetch_cnt + 32'd1;
            end
            if (i_jmp_en) begin
                r_flush_cnt <= r_flush_cnt + 32'd1;
            end
        end
    end

    assign o_perf_fetch_cnt = r_fetch_cnt;
    assign o_perf_flush_cnt = r_flush_cnt;
`endif

endmodule
